// File: rtl/display_scanner.sv
// Time-multiplexed digit scanner for a multi-digit seven-segment display.
// Double-buffers incoming values so that a frame is never shown half-updated.
module display_scanner #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 50000,
  parameter int DEADTIME = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     decpoints,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic [3:0]            binaryout,
  output logic                  decout,
  output logic [DIGITS-1:0]     digitsel,
  output logic                  frame_tick,
  output logic                  pending
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEADTIME);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*DIGITS-1:0]   disp_val;
  logic [DIGITS-1:0]     disp_dp;
  logic [4*DIGITS-1:0]   pend_val;
  logic [DIGITS-1:0]     pend_dp;
  logic                  pend_v;
  logic                  blank_q;
  logic                  frame_end;
  logic                  lz_run;
  logic [DIGITS-1:0]     blank;

  assign frame_end = (idx == IDX_LAST) && (cnt == CNT_LAST);

  // Slot counter and digit index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A load coinciding with the frame end goes straight to the display
  // registers, so the pending flag never rises for it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_val <= '0;
      disp_dp  <= '0;
      pend_val <= '0;
      pend_dp  <= '0;
      pend_v   <= 1'b0;
    end else begin
      if (load) begin
        pend_val <= value;
        pend_dp  <= decpoints;
      end
      if (frame_end) begin
        if (load) begin
          disp_val <= value;
          disp_dp  <= decpoints;
          pend_v   <= 1'b0;
        end else if (pend_v) begin
          disp_val <= pend_val;
          disp_dp  <= pend_dp;
          pend_v   <= 1'b0;
        end
      end else if (load) begin
        pend_v <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) blank_q <= 1'b0;
    else       blank_q <= blank_lz;
  end

  // Walk down from the most significant digit; blanking stops at the first
  // digit carrying a non-zero nibble or a decimal point. Digit 0 always shows.
  always_comb begin
    blank  = '0;
    lz_run = blank_q;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run   = lz_run && (disp_val[4*i +: 4] == 4'h0) && !disp_dp[i];
      blank[i] = lz_run;
    end
  end

  always_comb begin
    binaryout = 4'h0;
    decout    = 1'b0;
    digitsel  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        binaryout   = disp_val[4*i +: 4];
        decout      = disp_dp[i];
        digitsel[i] = (cnt >= CNT_DEAD) && !blank[i];
      end
    end
  end

  assign frame_tick = frame_end;
  assign pending    = pend_v;

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with DIGITS=4, PRESCALE=4, DEADTIME=1.
// Cycle 0 is the first cycle after reset is released.
module tb_display_scanner;

  logic        clk;
  logic        reset;
  logic [15:0] value;
  logic [3:0]  decpoints;
  logic        load;
  logic        blank_lz;
  logic [3:0]  binaryout;
  logic        decout;
  logic [3:0]  digitsel;
  logic        frame_tick;
  logic        pending;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [3:0] exp_q[$];

  display_scanner #(.DIGITS(4), .PRESCALE(4), .DEADTIME(1)) dut (
    .clk(clk), .reset(reset), .value(value), .decpoints(decpoints),
    .load(load), .blank_lz(blank_lz), .binaryout(binaryout), .decout(decout),
    .digitsel(digitsel), .frame_tick(frame_tick), .pending(pending)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    load      = 1'b0;
    blank_lz  = 1'b0;
    value     = '0;
    decpoints = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp);
    value     = v;
    decpoints = dp;
    load      = 1'b1;
    step();
    load      = 1'b0;
  endtask

  task automatic check_sel_at(input int c, input logic [3:0] exp, input string tag);
    goto_cycle(c);
    check(tag, 32'(digitsel), 32'(exp));
  endtask

  logic [3:0] e;

  initial begin
    reset = 1'b1; load = 1'b1; blank_lz = 1'b0; value = 16'hFFFF; decpoints = 4'hF;
    @(posedge clk);
    #1;
    check("rst_bin",     32'(binaryout),  32'h0);
    check("rst_dec",     32'(decout),     32'h0);
    check("rst_sel",     32'(digitsel),   32'h0);
    check("rst_tick",    32'(frame_tick), 32'h0);
    check("rst_pending", 32'(pending),    32'h0);

    // Reset/scan: two full frames with nothing loaded.
    do_reset();
    for (int s = 0; s < 4; s++) begin
      exp_q.push_back(4'h0);
      for (int k = 0; k < 3; k++) exp_q.push_back(4'(1 << s));
    end
    for (int c = 0; c < 32; c++) begin
      e = exp_q.pop_front();
      exp_q.push_back(e);
      check("scan_sel",  32'(digitsel),   32'(e));
      check("scan_bin",  32'(binaryout),  32'h0);
      check("scan_tick", 32'(frame_tick), (c == 15 || c == 31) ? 32'h1 : 32'h0);
      step();
    end

    // Load/commit.
    do_reset();
    goto_cycle(5);
    pulse_load(16'h12A4, 4'b0100);
    check("ld_pend6", 32'(pending), 32'h1);
    goto_cycle(15);
    check("ld_pend15", 32'(pending),   32'h1);
    check("ld_bin15",  32'(binaryout), 32'h0);
    goto_cycle(16);
    check("ld_pend16", 32'(pending),   32'h0);
    check("ld_bin16",  32'(binaryout), 32'h4);
    goto_cycle(17);
    check("ld_bin_d0", 32'(binaryout), 32'h4);
    check("ld_dec_d0", 32'(decout),    32'h0);
    check("ld_sel_d0", 32'(digitsel),  32'h1);
    goto_cycle(21);
    check("ld_bin_d1", 32'(binaryout), 32'hA);
    check("ld_dec_d1", 32'(decout),    32'h0);
    goto_cycle(25);
    check("ld_bin_d2", 32'(binaryout), 32'h2);
    check("ld_dec_d2", 32'(decout),    32'h1);
    goto_cycle(29);
    check("ld_bin_d3", 32'(binaryout), 32'h1);
    check("ld_dec_d3", 32'(decout),    32'h0);
    check("ld_sel_d3", 32'(digitsel),  32'h8);

    // Overwrite, then bypass on a frame_tick cycle.
    do_reset();
    goto_cycle(3);
    pulse_load(16'h1111, 4'b0000);
    goto_cycle(9);
    pulse_load(16'h2222, 4'b0000);
    goto_cycle(16);
    check("ow_bin16",  32'(binaryout), 32'h2);
    check("ow_pend16", 32'(pending),   32'h0);
    goto_cycle(31);
    check("bp_tick31", 32'(frame_tick), 32'h1);
    check("bp_pend31", 32'(pending),    32'h0);
    pulse_load(16'h3333, 4'b0000);
    check("bp_bin32",  32'(binaryout), 32'h3);
    check("bp_pend32", 32'(pending),   32'h0);
    goto_cycle(33);
    check("bp_pend33", 32'(pending),   32'h0);

    // Leading-zero blanking.
    do_reset();
    blank_lz = 1'b1;
    pulse_load(16'h0050, 4'b0000);
    check_sel_at(17, 4'h1, "lz50_d0");
    check_sel_at(21, 4'h2, "lz50_d1");
    check_sel_at(25, 4'h0, "lz50_d2");
    check_sel_at(29, 4'h0, "lz50_d3");
    goto_cycle(30);
    pulse_load(16'h0000, 4'b0000);
    check_sel_at(33, 4'h1, "lz00_d0");
    check_sel_at(37, 4'h0, "lz00_d1");
    check_sel_at(41, 4'h0, "lz00_d2");
    check_sel_at(45, 4'h0, "lz00_d3");
    goto_cycle(46);
    pulse_load(16'h0000, 4'b1000);
    check_sel_at(49, 4'h1, "lzdp_d0");
    check_sel_at(53, 4'h2, "lzdp_d1");
    check_sel_at(57, 4'h4, "lzdp_d2");
    check_sel_at(61, 4'h8, "lzdp_d3");
    check("lzdp_dec3", 32'(decout), 32'h1);

    // Reset in the middle of digit 2 with a value pending.
    do_reset();
    goto_cycle(2);
    pulse_load(16'hABCD, 4'b1111);
    goto_cycle(20);
    pulse_load(16'h5555, 4'b0000);
    goto_cycle(25);
    check("mr_bin_pre",  32'(binaryout), 32'hB);
    check("mr_sel_pre",  32'(digitsel),  32'h4);
    check("mr_pend_pre", 32'(pending),   32'h1);
    #2;
    load  = 1'b1;
    reset = 1'b1;
    #1;
    check("mr_bin",  32'(binaryout),  32'h0);
    check("mr_dec",  32'(decout),     32'h0);
    check("mr_sel",  32'(digitsel),   32'h0);
    check("mr_tick", 32'(frame_tick), 32'h0);
    check("mr_pend", 32'(pending),    32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    load  = 1'b0;
    cyc   = 0;
    check("mr_sel0",  32'(digitsel), 32'h0);
    check("mr_pend0", 32'(pending),  32'h0);
    step();
    check("mr_sel1", 32'(digitsel),  32'h1);
    check("mr_bin1", 32'(binaryout), 32'h0);
    goto_cycle(16);
    check("mr_bin16",  32'(binaryout), 32'h0);
    check("mr_pend16", 32'(pending),   32'h0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
